// File: rtl/multiplier_taint_pkg.sv
// Shared types and helpers for the per-bit taint-tracking shift-add multiplier.
// Latency: none (types, constants and combinational helper only).
// Backpressure: none.
package multiplier_taint_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest vector smear() handles. Callers zero-extend into it and keep the
  // low w bits, so products up to SMEAR_W-1 bits wide (WIDTH <= 127) work.
  localparam int SMEAR_W = 256;

  // Carry-propagation taint: every bit at or above the lowest set bit of v,
  // limited to the low w bits. For v == 0 the isolated lsb is 0, 0-1 is all
  // ones, and the inversion yields 0, so no special case is needed.
  function automatic logic [SMEAR_W-1:0] smear(input logic [SMEAR_W-1:0] v,
                                               input int w);
    logic [SMEAR_W-1:0] lsb;
    logic [SMEAR_W-1:0] one;
    logic [SMEAR_W-1:0] mask;
    one  = {{(SMEAR_W-1){1'b0}}, 1'b1};
    lsb  = v & (-v);
    mask = {SMEAR_W{1'b1}} >> (SMEAR_W - w);
    return ~(lsb - one) & mask;
  endfunction

endpackage

// File: rtl/multiplier_taint_step.sv
// One shift-add iteration with per-bit taint propagation (combinational).
// Ports: acc/acc_t running sum and taint, b/b_t operand B and taint, k bit
//   index, a_bit/a_bit_t = A[k] and its taint; acc_next/acc_t_next results.
// Latency: 0 cycles. Backpressure: none.
module multiplier_taint_step
  import multiplier_taint_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] acc_t,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   b_t,
  input  logic [CNT_W-1:0]   k,
  input  logic               a_bit,
  input  logic               a_bit_t,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] acc_t_next
);

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] addend_t;
  logic [SMEAR_W-1:0] smeared;
  logic               smear_unused;

  always_comb begin
    addend   = {{WIDTH{1'b0}}, b} << k;
    addend_t = '0;
    // A tainted selector bit means the add may or may not have happened, so
    // every bit from k upward is influenced regardless of B's taint.
    if (a_bit_t) begin
      addend_t = {(2*WIDTH){1'b1}} << k;
    end else if (a_bit) begin
      addend_t = {{WIDTH{1'b0}}, b_t} << k;
    end
    smeared    = smear(SMEAR_W'(acc_t | addend_t), 2*WIDTH);
    acc_next   = a_bit ? acc + addend : acc;
    acc_t_next = (a_bit | a_bit_t) ? smeared[2*WIDTH-1:0] : acc_t;
  end

  // Upper smear bits are always zero by construction.
  assign smear_unused = ^smeared[SMEAR_W-1:2*WIDTH];

endmodule

// File: rtl/multiplier_taint_track_nbit.sv
// Sequential signed/unsigned shift-add multiplier with per-bit and control-flow taint.
// Latency: WIDTH+2 cycles start-to-done (data dependent with MULT_EARLY_TERM_EN).
// Backpressure: start ignored while busy; accepted in IDLE or the productDone cycle.
// Ports: start/start_t request, signed_mode(+_t), multiplier/multiplicand with
//   per-bit taints in; product/product_t, busy/busy_t, productDone/productDone_t out.
// Optional macro MULT_EARLY_TERM_EN: stop RUN once the remaining A bits are
//   zero and untainted; done timing then carries A's taint onto busy_t/productDone_t.
module multiplier_taint_track_nbit
  import multiplier_taint_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 start_t,
  input  logic                 signed_mode,
  input  logic                 signed_mode_t,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplier_t,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplicand_t,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   product_t,
  output logic                 busy,
  output logic                 busy_t,
  output logic                 productDone,
  output logic                 productDone_t
);

  localparam int PW    = 2*WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WIDTH-1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_mag, a_mag_t, b_mag, b_mag_t;
  logic [PW-1:0]    acc, acc_t, acc_nx, acc_t_nx;
  logic             neg, neg_t, ctl_t, flow_t;

  // Operand capture: magnitudes in signed mode, sign taint widens to the whole operand.
  logic             a_neg, b_neg, a_sign_t, b_sign_t, cap_neg_t, cap_flow_t;
  logic [WIDTH-1:0] cap_a, cap_a_t, cap_b, cap_b_t;

  always_comb begin
    a_neg     = signed_mode & multiplier[WIDTH-1];
    b_neg     = signed_mode & multiplicand[WIDTH-1];
    a_sign_t  = signed_mode_t | (signed_mode & multiplier_t[WIDTH-1]);
    b_sign_t  = signed_mode_t | (signed_mode & multiplicand_t[WIDTH-1]);
    cap_neg_t = a_sign_t | b_sign_t;
    cap_a     = a_neg ? -multiplier : multiplier;
    cap_b     = b_neg ? -multiplicand : multiplicand;
    cap_a_t   = a_sign_t ? {WIDTH{1'b1}} : multiplier_t;
    cap_b_t   = b_sign_t ? {WIDTH{1'b1}} : multiplicand_t;
  end

  logic early_stop;
`ifdef MULT_EARLY_TERM_EN
  // Remaining selector bits all zero and untainted: later iterations are no-ops.
  assign early_stop = ((a_mag >> cnt) == '0) && ((a_mag_t >> cnt) == '0);
  // Done timing now depends on A, so any A taint reaches the control outputs.
  assign cap_flow_t = start_t | (|cap_a_t);
`else
  assign early_stop = 1'b0;
  assign cap_flow_t = start_t;
`endif

  multiplier_taint_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step (
    .acc        (acc),
    .acc_t      (acc_t),
    .b          (b_mag),
    .b_t        (b_mag_t),
    .k          (cnt),
    .a_bit      (a_mag[cnt]),
    .a_bit_t    (a_mag_t[cnt]),
    .acc_next   (acc_nx),
    .acc_t_next (acc_t_nx)
  );

  // Sign fixup: negation is a carry chain from bit 0, hence the smear.
  logic [PW-1:0]      fix_val, fix_t;
  logic [SMEAR_W-1:0] fix_smear;
  logic               fix_smear_unused;

  always_comb begin
    fix_smear = smear(SMEAR_W'(acc_t), PW);
    fix_val   = neg ? -acc : acc;
    fix_t     = neg ? fix_smear[PW-1:0] : acc_t;
    if (neg_t | ctl_t) begin
      fix_t = {PW{1'b1}};
    end
  end

  assign fix_smear_unused = ^fix_smear[SMEAR_W-1:PW];

  assign busy_t        = flow_t;
  assign productDone_t = flow_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_mag       <= '0;
      a_mag_t     <= '0;
      b_mag       <= '0;
      b_mag_t     <= '0;
      acc         <= '0;
      acc_t       <= '0;
      neg         <= 1'b0;
      neg_t       <= 1'b0;
      ctl_t       <= 1'b0;
      flow_t      <= 1'b0;
      product     <= '0;
      product_t   <= '0;
      busy        <= 1'b0;
      productDone <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          productDone <= 1'b0;
          if (start) begin
            a_mag   <= cap_a;
            a_mag_t <= cap_a_t;
            b_mag   <= cap_b;
            b_mag_t <= cap_b_t;
            neg     <= a_neg ^ b_neg;
            neg_t   <= cap_neg_t;
            ctl_t   <= start_t;
            flow_t  <= cap_flow_t;
            acc     <= '0;
            acc_t   <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (early_stop) begin
            state <= FIXUP;
          end else begin
            acc   <= acc_nx;
            acc_t <= acc_t_nx;
            if (cnt == LAST_K) begin
              state <= FIXUP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        FIXUP: begin
          product     <= fix_val;
          product_t   <= fix_t;
          busy        <= 1'b0;
          productDone <= 1'b1;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
